// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory-controller port: registered
// round-robin ownership with a burst cap, and read data steered back by tag.
module mem_port_arbiter #(
    parameter int ADDR_W    = 128,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              vf0,
    input  logic              vf1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic              mem_vf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    localparam logic [7:0] CNT_MAX = 8'(MAX_BURST);

    state_t            r_state;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rr;
    logic [7:0]        r_cnt;
    tag_t              r_tag [RD_LAT];
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic       w_acc0;
    logic       w_acc1;
    logic       w_acc;
    logic       w_own0;
    logic       w_req_own;
    logic       w_req_oth;
    logic       w_leave;
    logic [7:0] w_cnt_next;
    tag_t       w_tag_out;

    assign w_acc0    = r_gnt0 & req0;
    assign w_acc1    = r_gnt1 & req1;
    assign w_acc     = w_acc0 | w_acc1;
    assign w_own0    = (r_state == OWN0);
    assign w_req_own = w_own0 ? req0 : req1;
    assign w_req_oth = w_own0 ? req1 : req0;

    // The cap is judged on the count including this cycle's beat, so the
    // owner hands over right after its MAX_BURST-th accepted beat.
    assign w_cnt_next = (w_acc && r_cnt != CNT_MAX) ? r_cnt + 8'd1 : r_cnt;
    assign w_leave    = !w_req_own || (w_cnt_next == CNT_MAX && w_req_oth);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_rr    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 && !(req1 && r_rr)) begin
                        r_state <= OWN0;
                        r_gnt0  <= 1'b1;
                    end else if (req1) begin
                        r_state <= OWN1;
                        r_gnt1  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (w_leave) begin
                        r_cnt <= '0;
                        r_rr  <= w_own0;
                        if (w_req_oth) begin
                            r_state <= w_own0 ? OWN1 : OWN0;
                            r_gnt0  <= !w_own0;
                            r_gnt1  <= w_own0;
                        end else begin
                            r_state <= IDLE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        mem_we   = 1'b0;
        mem_vf   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (w_acc0) begin
            mem_we   = we0;
            mem_vf   = vf0;
            mem_addr = addr0;
            mem_wd   = wd0;
        end else if (w_acc1) begin
            mem_we   = we1;
            mem_vf   = vf1;
            mem_addr = addr1;
            mem_wd   = wd1;
        end
    end

    // NOTE: the tag pipeline is reset even though it is storage, because its
    // valid bits drive rvalid and stale tags must not survive a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_tag[0].valid <= w_acc & ~mem_we;
            r_tag[0].owner <= w_acc1;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (rvalid0) begin
                r_rdata0 <= mem_rd;
            end
            if (rvalid1) begin
                r_rdata1 <= mem_rd;
            end
        end
    end

    // mem_rd is live in the cycle the tag emerges, so it is passed straight
    // through then and held afterwards.
    assign w_tag_out = r_tag[RD_LAT-1];
    assign rvalid0   = w_tag_out.valid & ~w_tag_out.owner;
    assign rvalid1   = w_tag_out.valid & w_tag_out.owner;
    assign rdata0    = rvalid0 ? mem_rd : r_rdata0;
    assign rdata1    = rvalid1 ? mem_rd : r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RD_LAT=1/MAX_BURST=8, one with
// RD_LAT=3/MAX_BURST=1, each with a read-return scoreboard and a memory model.
module tb_mem_port_arbiter;

    localparam int RD_LAT_A = 1;
    localparam int RD_LAT_B = 3;

    typedef struct {
        bit           owner;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic sw_inicio = 1'b1;

    logic         a_req0, a_req1, a_we0, a_we1, a_vf0, a_vf1;
    logic [127:0] a_addr0, a_addr1, a_wd0, a_wd1;
    logic         a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_we, a_mem_vf;
    logic [127:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wd, a_mem_rd;

    logic         b_req0, b_req1, b_we0, b_we1, b_vf0, b_vf1;
    logic [127:0] b_addr0, b_addr1, b_wd0, b_wd1;
    logic         b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we, b_mem_vf;
    logic [127:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wd, b_mem_rd;

    logic [127:0] a_pipe [RD_LAT_A];
    logic [127:0] b_pipe [RD_LAT_B];
    logic [127:0] mem_store [int];
    exp_t         q_a [$];
    exp_t         q_b [$];
    logic [127:0] last_a [2];
    logic [127:0] last_b [2];

    mem_port_arbiter #(.ADDR_W(128), .DATA_W(128), .MAX_BURST(8), .RD_LAT(RD_LAT_A)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1), .vf0(a_vf0), .vf1(a_vf1),
        .addr0(a_addr0), .addr1(a_addr1), .wd0(a_wd0), .wd1(a_wd1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
        .rdata0(a_rdata0), .rdata1(a_rdata1),
        .mem_we(a_mem_we), .mem_vf(a_mem_vf), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd),
        .mem_rd(a_mem_rd)
    );

    mem_port_arbiter #(.ADDR_W(128), .DATA_W(128), .MAX_BURST(1), .RD_LAT(RD_LAT_B)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1), .vf0(b_vf0), .vf1(b_vf1),
        .addr0(b_addr0), .addr1(b_addr1), .wd0(b_wd0), .wd1(b_wd1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_we(b_mem_we), .mem_vf(b_mem_vf), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd),
        .mem_rd(b_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: preset ROM/RAM words, switch registers, written words.
    function automatic logic [127:0] mem_read(input logic [127:0] a);
        if (a >= 128'd241000 && a <= 128'd241020) begin
            return (a == 128'd241000) ? 128'(sw_inicio) : '0;
        end
        if (mem_store.exists(int'(a[31:0]))) begin
            return mem_store[int'(a[31:0])];
        end
        case (a)
            128'd120005: return 128'hABCD;
            128'd120020: return 128'h1000;
            128'd120030: return 128'h2000;
            default:     return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        a_pipe[0] <= mem_read(a_mem_addr);
        for (int i = 1; i < RD_LAT_A; i++) a_pipe[i] <= a_pipe[i-1];
        b_pipe[0] <= mem_read(b_mem_addr);
        for (int i = 1; i < RD_LAT_B; i++) b_pipe[i] <= b_pipe[i-1];
        if (a_mem_we) mem_store[int'(a_mem_addr[31:0])] = a_mem_wd;
        if (b_mem_we) mem_store[int'(b_mem_addr[31:0])] = b_mem_wd;
    end

    assign a_mem_rd = a_pipe[RD_LAT_A-1];
    assign b_mem_rd = b_pipe[RD_LAT_B-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_a(input bit o, input logic [127:0] d);
        q_a.push_back('{owner: o, data: d, cyc: cyc + RD_LAT_A});
    endtask

    task automatic push_b(input bit o, input logic [127:0] d);
        q_b.push_back('{owner: o, data: d, cyc: cyc + RD_LAT_B});
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_gnt0"}, 128'(a_gnt0), '0);
        check({tag, "_gnt1"}, 128'(a_gnt1), '0);
        check({tag, "_rvalid0"}, 128'(a_rvalid0), '0);
        check({tag, "_rvalid1"}, 128'(a_rvalid1), '0);
        check({tag, "_mem_we"}, 128'(a_mem_we), '0);
        check({tag, "_mem_vf"}, 128'(a_mem_vf), '0);
        check({tag, "_mem_addr"}, a_mem_addr, '0);
        check({tag, "_mem_wd"}, a_mem_wd, '0);
        check({tag, "_rdata0"}, a_rdata0, '0);
        check({tag, "_rdata1"}, a_rdata1, '0);
    endtask

    task automatic check_b_zero(input string tag);
        check({tag, "_gnt0"}, 128'(b_gnt0), '0);
        check({tag, "_gnt1"}, 128'(b_gnt1), '0);
        check({tag, "_rvalid0"}, 128'(b_rvalid0), '0);
        check({tag, "_rvalid1"}, 128'(b_rvalid1), '0);
        check({tag, "_mem_we"}, 128'(b_mem_we), '0);
        check({tag, "_mem_vf"}, 128'(b_mem_vf), '0);
        check({tag, "_mem_addr"}, b_mem_addr, '0);
        check({tag, "_mem_wd"}, b_mem_wd, '0);
    endtask

    // Read-return monitors: every rvalid pops one expected entry.
    always @(negedge clk) begin
        if (rst_a && (a_rvalid0 || a_rvalid1)) begin
            if (a_rvalid0 && a_rvalid1) begin
                check("a_rvalid_both", 128'(a_rvalid0 & a_rvalid1), '0);
            end else if (q_a.size() == 0) begin
                check("a_rvalid_unexpected", 128'({a_rvalid1, a_rvalid0}), '0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_rv_owner", 128'(a_rvalid1), 128'(e.owner));
                check("a_rv_data", e.owner ? a_rdata1 : a_rdata0, e.data);
                check("a_rv_cycle", 128'(cyc), 128'(e.cyc));
                check("a_rd_hold", e.owner ? a_rdata0 : a_rdata1, last_a[!e.owner]);
                last_a[e.owner] = e.data;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && (b_rvalid0 || b_rvalid1)) begin
            if (b_rvalid0 && b_rvalid1) begin
                check("b_rvalid_both", 128'(b_rvalid0 & b_rvalid1), '0);
            end else if (q_b.size() == 0) begin
                check("b_rvalid_unexpected", 128'({b_rvalid1, b_rvalid0}), '0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_rv_owner", 128'(b_rvalid1), 128'(e.owner));
                check("b_rv_data", e.owner ? b_rdata1 : b_rdata0, e.data);
                check("b_rv_cycle", 128'(cyc), 128'(e.cyc));
                check("b_rd_hold", e.owner ? b_rdata0 : b_rdata1, last_b[!e.owner]);
                last_b[e.owner] = e.data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int o;
        {a_req0, a_req1, a_we0, a_we1, a_vf0, a_vf1} = '0;
        {a_addr0, a_addr1, a_wd0, a_wd1} = '0;
        {b_req0, b_req1, b_we0, b_we1, b_vf0, b_vf1} = '0;
        {b_addr0, b_addr1, b_wd0, b_wd1} = '0;
        last_a = '{default: '0};
        last_b = '{default: '0};
        rst_a = 1'b0;
        rst_b = 1'b0;
        smp();
        check_a_zero("reset_a");
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Single read on A, RD_LAT=1.
        tick(); a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 128'd120005;
        smp(); check("t1_gnt0_c0", 128'(a_gnt0), '0);
        tick(); smp();
        check("t1_gnt0_c1", 128'(a_gnt0), 128'd1);
        check("t1_gnt1_c1", 128'(a_gnt1), '0);
        check("t1_mem_addr", a_mem_addr, 128'd120005);
        check("t1_mem_we", 128'(a_mem_we), '0);
        push_a(1'b0, 128'hABCD);
        tick(); a_req0 = 1'b0;
        smp();
        check("t1_gnt0_drop", 128'(a_gnt0), 128'd1);
        check("t1_mem_addr_drop", a_mem_addr, '0);
        tick(); smp(); check("t1_gnt0_idle", 128'(a_gnt0), '0);
        tick(); tick();

        // Reset A (restores rr=0), then both requesters held.
        tick(); rst_a = 1'b0; #1;
        check_a_zero("reset_a2");
        last_a = '{default: '0};
        tick(); rst_a = 1'b1;
        tick();
        a_req0 = 1'b1; a_req1 = 1'b1; a_we0 = 1'b0; a_we1 = 1'b0;
        a_addr0 = 128'd120020; a_addr1 = 128'd120030; a_vf0 = 1'b1; a_vf1 = 1'b0;
        smp();
        check("t2_gnt0_c0", 128'(a_gnt0), '0);
        check("t2_gnt1_c0", 128'(a_gnt1), '0);
        for (int c = 1; c <= 20; c++) begin
            tick(); smp();
            o = (c <= 8) ? 0 : (c <= 16) ? 1 : 0;
            check("t2_gnt0", 128'(a_gnt0), 128'(o == 0));
            check("t2_gnt1", 128'(a_gnt1), 128'(o == 1));
            check("t2_mem_addr", a_mem_addr, (o == 1) ? 128'd120030 : 128'd120020);
            check("t2_mem_vf", 128'(a_mem_vf), 128'(o == 0));
            push_a(o[0], (o == 1) ? 128'h2000 : 128'h1000);
        end
        tick(); a_req0 = 1'b0; a_req1 = 1'b0; a_vf0 = 1'b0;
        smp();
        check("t2_gnt0_drop", 128'(a_gnt0), 128'd1);
        check("t2_mem_addr_drop", a_mem_addr, '0);
        tick(); tick();

        // Write then read from requester 1.
        tick(); a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 128'd120010; a_wd1 = 128'h55;
        smp(); check("t3_mem_we_idle", 128'(a_mem_we), '0);
        tick(); smp();
        check("t3_gnt1_wr", 128'(a_gnt1), 128'd1);
        check("t3_mem_we_wr", 128'(a_mem_we), 128'd1);
        check("t3_mem_addr_wr", a_mem_addr, 128'd120010);
        check("t3_mem_wd_wr", a_mem_wd, 128'h55);
        tick(); a_we1 = 1'b0;
        smp();
        check("t3_gnt1_rd", 128'(a_gnt1), 128'd1);
        check("t3_mem_we_rd", 128'(a_mem_we), '0);
        check("t3_mem_addr_rd", a_mem_addr, 128'd120010);
        push_a(1'b1, 128'h55);
        tick(); a_req1 = 1'b0; a_we1 = 1'b1;
        smp();
        check("t3_gnt1_drop", 128'(a_gnt1), 128'd1);
        check("t3_mem_we_stray", 128'(a_mem_we), '0);
        check("t3_mem_wd_stray", a_mem_wd, '0);
        tick(); a_we1 = 1'b0;
        smp(); check("t3_gnt1_idle", 128'(a_gnt1), '0);

        // Switch register read.
        tick(); a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 128'd241000;
        smp();
        tick(); smp();
        check("t4_gnt0", 128'(a_gnt0), 128'd1);
        check("t4_mem_addr", a_mem_addr, 128'd241000);
        push_a(1'b0, 128'd1);
        tick(); a_req0 = 1'b0;
        smp();
        tick(); smp();

        // Short write request dropped before the grant.
        tick(); a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 128'd120050; a_wd0 = 128'hDEAD;
        smp();
        check("t5_gnt0_c0", 128'(a_gnt0), '0);
        check("t5_mem_we_c0", 128'(a_mem_we), '0);
        tick(); a_req0 = 1'b0;
        smp();
        check("t5_gnt0_c1", 128'(a_gnt0), 128'd1);
        check("t5_mem_we_c1", 128'(a_mem_we), '0);
        tick(); smp();
        check("t5_gnt0_c2", 128'(a_gnt0), '0);
        check("t5_mem_we_c2", 128'(a_mem_we), '0);
        tick(); a_we0 = 1'b0;
        smp(); check("t5_gnt0_c3", 128'(a_gnt0), '0);

        // B (RD_LAT=3, MAX_BURST=1): set rr=1, two reads in flight, then reset.
        tick(); b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 128'd120040; b_wd0 = 128'h77;
        smp();
        tick(); b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 128'd120005;
        smp();
        check("b1_gnt0_wr", 128'(b_gnt0), 128'd1);
        check("b1_mem_we_wr", 128'(b_mem_we), 128'd1);
        tick(); b_req0 = 1'b0;
        smp();
        check("b1_gnt1_rd1", 128'(b_gnt1), 128'd1);
        check("b1_gnt0_rd1", 128'(b_gnt0), '0);
        check("b1_mem_we_rd1", 128'(b_mem_we), '0);
        check("b1_mem_addr_rd1", b_mem_addr, 128'd120005);
        tick(); b_addr1 = 128'd120020;
        smp();
        check("b1_gnt1_rd2", 128'(b_gnt1), 128'd1);
        check("b1_mem_addr_rd2", b_mem_addr, 128'd120020);
        tick(); b_req1 = 1'b0; rst_b = 1'b0; #1;
        check_b_zero("b1_reset");
        tick(); rst_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(); smp();
            check("b1_gnt0_quiet", 128'(b_gnt0), '0);
        end

        // B alternation from IDLE after reset: rr=0 so requester 0 goes first.
        tick();
        b_req0 = 1'b1; b_req1 = 1'b1; b_we0 = 1'b0; b_we1 = 1'b0;
        b_addr0 = 128'd120020; b_addr1 = 128'd120030;
        smp();
        check("b2_gnt0_c0", 128'(b_gnt0), '0);
        check("b2_gnt1_c0", 128'(b_gnt1), '0);
        for (int c = 1; c <= 6; c++) begin
            tick(); smp();
            o = (c % 2 == 1) ? 0 : 1;
            check("b2_gnt0", 128'(b_gnt0), 128'(o == 0));
            check("b2_gnt1", 128'(b_gnt1), 128'(o == 1));
            check("b2_mem_addr", b_mem_addr, (o == 1) ? 128'd120030 : 128'd120020);
            push_b(o[0], (o == 1) ? 128'h2000 : 128'h1000);
        end
        tick(); b_req0 = 1'b0; b_req1 = 1'b0;
        smp();
        for (int c = 0; c < 6; c++) tick();
        smp();

        check("a_scoreboard_drained", 128'(q_a.size()), '0);
        check("b_scoreboard_drained", 128'(q_b.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
